// File: rtl/neighbor_scan_ctrl.sv
// -----------------------------------------------------------------------------
// neighbor_scan_ctrl
//
// Sequencer and arbiter in front of the shared 2048x8 node memory (16-bit
// big-endian word port, combinational read). On an accepted start it walks the
// neighbour table. Every neighbour whose clusterID differs from this node's
// cluster has its neighborID appended to the betterneighbors table, up to
// MAX_OUT entries. The number written goes to betterneighborCount. While idle,
// the external requester is passed straight through to the memory.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   start               begin a scan (sampled only while idle)
//   my_cluster_id       this node's cluster, latched when start is accepted
//   busy                scan in progress (includes the DONE cycle)
//   done                one-cycle pulse in the final cycle of a scan
//   match_count         neighbours written by the last completed scan
//   overflow            last scan found more than MAX_OUT matches
//   mem_address/_wr_en/_wdata  memory request, muxed between FSM and ext_*
//   mem_rdata           memory read data (combinational)
//   ext_address/_wr_en/_wdata  external requester, honoured only while idle
//   ext_rdata           always equal to mem_rdata
//   ext_grant           1 while idle
// -----------------------------------------------------------------------------
module neighbor_scan_ctrl #(
    parameter logic [15:0] CNT_ADDR      = 16'h068A,
    parameter logic [15:0] NID_BASE      = 16'h0048,
    parameter logic [15:0] CID_BASE      = 16'h00C8,
    parameter logic [15:0] OUT_BASE      = 16'h0668,
    parameter logic [15:0] OUT_CNT_ADDR  = 16'h068C,
    parameter int unsigned MAX_NEIGHBORS = 64,
    parameter int unsigned MAX_OUT       = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] my_cluster_id,
    output logic        busy,
    output logic        done,
    output logic [4:0]  match_count,
    output logic        overflow,
    output logic [15:0] mem_address,
    output logic        mem_wr_en,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] ext_address,
    input  logic        ext_wr_en,
    input  logic [15:0] ext_wdata,
    output logic [15:0] ext_rdata,
    output logic        ext_grant
);

    localparam logic [15:0] MAX_NB_16 = 16'(MAX_NEIGHBORS);
    localparam logic [6:0]  MAX_NB_7  = 7'(MAX_NEIGHBORS);
    localparam logic [4:0]  MAX_OUT_5 = 5'(MAX_OUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CNT,
        S_RD_CID,
        S_RD_NID,
        S_WR_OUT,
        S_NEXT,
        S_WR_CNT,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [15:0] my_cid_q;
    logic [6:0]  cnt_q;
    logic [5:0]  idx_q;
    logic [4:0]  found_q;
    logic [15:0] nid_q;
    logic        busy_q;
    logic        done_q;
    logic [4:0]  match_count_q;
    logic        overflow_q;

    // Neighbour count as read from memory, clamped to the table size.
    logic [6:0]  cnt_d;
    // idx is the last valid entry; cnt_q >= 1 whenever the walk is running.
    logic        last_entry;

    assign cnt_d      = (mem_rdata > MAX_NB_16) ? MAX_NB_7 : mem_rdata[6:0];
    assign last_entry = ({1'b0, idx_q} == (cnt_q - 7'd1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            my_cid_q      <= 16'h0000;
            cnt_q         <= 7'd0;
            idx_q         <= 6'd0;
            found_q       <= 5'd0;
            nid_q         <= 16'h0000;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            match_count_q <= 5'd0;
            overflow_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        my_cid_q   <= my_cluster_id;
                        idx_q      <= 6'd0;
                        found_q    <= 5'd0;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RD_CNT;
                    end
                end
                S_RD_CNT: begin
                    cnt_q <= cnt_d;
                    if (cnt_d == 7'd0) begin
                        state_q <= S_WR_CNT;
                    end else begin
                        state_q <= S_RD_CID;
                    end
                end
                S_RD_CID: begin
                    if (mem_rdata != my_cid_q) begin
                        if (found_q != MAX_OUT_5) begin
                            state_q <= S_RD_NID;
                        end else begin
                            // Table already full: remember the loss, skip entry.
                            overflow_q <= 1'b1;
                            state_q    <= S_NEXT;
                        end
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_RD_NID: begin
                    nid_q   <= mem_rdata;
                    state_q <= S_WR_OUT;
                end
                S_WR_OUT: begin
                    found_q <= found_q + 5'd1;
                    state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (last_entry) begin
                        state_q <= S_WR_CNT;
                    end else begin
                        idx_q   <= idx_q + 6'd1;
                        state_q <= S_RD_CID;
                    end
                end
                S_WR_CNT: begin
                    // done is registered so it is high exactly during DONE.
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q        <= 1'b0;
                    busy_q        <= 1'b0;
                    match_count_q <= found_q;
                    state_q       <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Memory port mux: the external requester owns the memory only in IDLE;
    // in every other state its write enable is blocked.
    always_comb begin
        mem_address = 16'h0000;
        mem_wr_en   = 1'b0;
        mem_wdata   = 16'h0000;
        case (state_q)
            S_IDLE: begin
                mem_address = ext_address;
                mem_wr_en   = ext_wr_en;
                mem_wdata   = ext_wdata;
            end
            S_RD_CNT: begin
                mem_address = CNT_ADDR;
            end
            S_RD_CID: begin
                mem_address = CID_BASE + {9'b0, idx_q, 1'b0};
            end
            S_RD_NID: begin
                mem_address = NID_BASE + {9'b0, idx_q, 1'b0};
            end
            S_WR_OUT: begin
                mem_address = OUT_BASE + {10'b0, found_q, 1'b0};
                mem_wr_en   = 1'b1;
                mem_wdata   = nid_q;
            end
            S_WR_CNT: begin
                mem_address = OUT_CNT_ADDR;
                mem_wr_en   = 1'b1;
                mem_wdata   = {11'b0, found_q};
            end
            default: begin
            end
        endcase
    end

    assign ext_rdata   = mem_rdata;
    assign ext_grant   = (state_q == S_IDLE);
    assign busy        = busy_q;
    assign done        = done_q;
    assign match_count = match_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_neighbor_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_neighbor_scan_ctrl
//
// Bench for neighbor_scan_ctrl. It holds a 2048x8 big-endian memory model and
// a shadow copy that a table-driven reference model updates with the expected
// scan results. Directed scenarios are followed by randomized scans.
// -----------------------------------------------------------------------------
module tb_neighbor_scan_ctrl;

  localparam logic [15:0] CNT_ADDR     = 16'h068A;
  localparam logic [15:0] NID_BASE     = 16'h0048;
  localparam logic [15:0] CID_BASE     = 16'h00C8;
  localparam logic [15:0] OUT_BASE     = 16'h0668;
  localparam logic [15:0] OUT_CNT_ADDR = 16'h068C;
  localparam int          TIMEOUT      = 2000;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] my_cluster_id;
  logic        busy;
  logic        done;
  logic [4:0]  match_count;
  logic        overflow;
  logic [15:0] mem_address;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] ext_address;
  logic        ext_wr_en;
  logic [15:0] ext_wdata;
  logic [15:0] ext_rdata;
  logic        ext_grant;

  logic [7:0]  mem     [0:2047];
  logic [7:0]  ref_mem [0:2047];
  logic        mem_clr;
  logic [10:0] ma;

  int total = 0;
  int bad   = 0;
  int exp_mc;
  int exp_cyc;
  bit exp_ovf;

  always #5 clock = ~clock;

  neighbor_scan_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .my_cluster_id(my_cluster_id),
    .busy         (busy),
    .done         (done),
    .match_count  (match_count),
    .overflow     (overflow),
    .mem_address  (mem_address),
    .mem_wr_en    (mem_wr_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .ext_address  (ext_address),
    .ext_wr_en    (ext_wr_en),
    .ext_wdata    (ext_wdata),
    .ext_rdata    (ext_rdata),
    .ext_grant    (ext_grant)
  );

  assign ma        = mem_address[10:0];
  assign mem_rdata = {mem[ma], mem[ma + 11'd1]};

  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
    end else if (mem_wr_en) begin
      mem[ma]         <= mem_wdata[15:8];
      mem[ma + 11'd1] <= mem_wdata[7:0];
    end
  end

  function automatic logic [15:0] mword(input logic [15:0] a);
    return {mem[a[10:0]], mem[a[10:0] + 11'd1]};
  endfunction

  function automatic logic [15:0] rword(input logic [15:0] a);
    return {ref_mem[a[10:0]], ref_mem[a[10:0] + 11'd1]};
  endfunction

  function automatic void wref(input logic [15:0] a, input logic [15:0] d);
    ref_mem[a[10:0]]         = d[15:8];
    ref_mem[a[10:0] + 11'd1] = d[7:0];
  endfunction

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Reference: apply the scan rules to the shadow memory and predict results.
  function automatic void model(input logic [15:0] my);
    int cnt, n, cyc;
    bit ovf;
    cnt = int'(rword(CNT_ADDR));
    if (cnt > 64) cnt = 64;
    n = 0; ovf = 0; cyc = 3;
    for (int i = 0; i < cnt; i++) begin
      if (rword(CID_BASE + 16'(2 * i)) != my) begin
        if (n < 16) begin
          wref(OUT_BASE + 16'(2 * n), rword(NID_BASE + 16'(2 * i)));
          n++;
          cyc += 4;
        end else begin
          ovf = 1;
          cyc += 2;
        end
      end else begin
        cyc += 2;
      end
    end
    wref(OUT_CNT_ADDR, 16'(n));
    exp_mc = n; exp_ovf = ovf; exp_cyc = cyc;
  endfunction

  // Called at a negedge with the DUT idle; returns at the next negedge.
  task automatic ext_write(input logic [15:0] a, input logic [15:0] d);
    ext_address = a; ext_wdata = d; ext_wr_en = 1'b1;
    @(negedge clock);
    ext_wr_en = 1'b0;
    wref(a, d);
  endtask

  task automatic fill_out_garbage(input logic [15:0] v);
    for (int i = 0; i < 16; i++) ext_write(OUT_BASE + 16'(2 * i), v);
    ext_write(OUT_CNT_ADDR, v);
  endtask

  task automatic preload_s1();
    logic [15:0] ids [4] = '{16'd3, 16'd1, 16'd10, 16'd6};
    logic [15:0] cid [4] = '{16'd1, 16'd1, 16'd2, 16'd3};
    ext_write(CNT_ADDR, 16'd4);
    for (int i = 0; i < 4; i++) begin
      ext_write(NID_BASE + 16'(2 * i), ids[i]);
      ext_write(CID_BASE + 16'(2 * i), cid[i]);
    end
    fill_out_garbage(16'hAAAA);
  endtask

  // Start a scan at a negedge; cyc counts busy cycles up to and including
  // the one where done is seen. Returns at that negedge.
  task automatic run_scan(input logic [15:0] my, input bit meddle, input bit hold,
                          output int cyc, output bit grant_bad);
    my_cluster_id = my; start = 1'b1; grant_bad = 0;
    @(negedge clock);
    cyc = 1;
    if (!hold) start = 1'b0;
    while (done !== 1'b1 && cyc < TIMEOUT) begin
      if (meddle) begin
        ext_address = 16'h0700; ext_wdata = 16'h1234; ext_wr_en = 1'b1;
        if (ext_grant !== 1'b0) grant_bad = 1;
      end
      @(negedge clock);
      cyc++;
    end
    ext_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (match_count !== 5'd0) begin bad++; $display("FAIL reset_mc: got %0d expected 0", match_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    total++; if (ext_grant !== 1'b1) begin bad++; $display("FAIL reset_grant: got %b expected 1", ext_grant); end
  endtask

  task automatic test_preload();
    int cyc; bit gb;
    preload_s1();
    model(16'd1);
    run_scan(16'd1, 0, 0, cyc, gb);
    total++; if (cyc != 15) begin bad++; $display("FAIL s1_cycles: got %0d expected 15", cyc); end
    @(negedge clock);
    total++; if (mword(16'h0668) !== 16'd10) begin bad++; $display("FAIL s1_out0: got %0d expected 10", mword(16'h0668)); end
    total++; if (mword(16'h066A) !== 16'd6) begin bad++; $display("FAIL s1_out1: got %0d expected 6", mword(16'h066A)); end
    total++; if (mword(16'h068C) !== 16'd2) begin bad++; $display("FAIL s1_count: got %0d expected 2", mword(16'h068C)); end
    total++; if (match_count !== 5'd2) begin bad++; $display("FAIL s1_mc: got %0d expected 2", match_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL s1_ovf: got %b expected 0", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL s1_busy_after: got %b expected 0", busy); end
    total++; if (mem_diff() != 0) begin bad++; $display("FAIL s1_memory: got %0d differing bytes expected 0", mem_diff()); end
  endtask

  task automatic test_zero_count();
    int cyc; bit gb;
    ext_write(CNT_ADDR, 16'd0);
    fill_out_garbage(16'h5555);
    model(16'd1);
    run_scan(16'd1, 0, 0, cyc, gb);
    total++; if (cyc != 3) begin bad++; $display("FAIL zero_cycles: got %0d expected 3", cyc); end
    @(negedge clock);
    total++; if (mword(OUT_CNT_ADDR) !== 16'd0) begin bad++; $display("FAIL zero_count: got %0d expected 0", mword(OUT_CNT_ADDR)); end
    total++; if (match_count !== 5'd0) begin bad++; $display("FAIL zero_mc: got %0d expected 0", match_count); end
    total++; if (mem_diff() != 0) begin bad++; $display("FAIL zero_memory: got %0d differing bytes expected 0", mem_diff()); end
  endtask

  task automatic test_overflow();
    int cyc; bit gb;
    ext_write(CNT_ADDR, 16'd20);
    for (int i = 0; i < 20; i++) begin
      ext_write(NID_BASE + 16'(2 * i), 16'(100 + i));
      ext_write(CID_BASE + 16'(2 * i), 16'd5);
    end
    fill_out_garbage(16'hAAAA);
    model(16'd1);
    run_scan(16'd1, 0, 0, cyc, gb);
    total++; if (cyc != 75) begin bad++; $display("FAIL ovf_cycles: got %0d expected 75", cyc); end
    @(negedge clock);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (mword(OUT_BASE + 16'(2 * i)) !== 16'(100 + i)) begin
        bad++; $display("FAIL ovf_out%0d: got %0d expected %0d", i, mword(OUT_BASE + 16'(2 * i)), 100 + i);
      end
    end
    total++; if (mword(OUT_CNT_ADDR) !== 16'd16) begin bad++; $display("FAIL ovf_count: got %0d expected 16", mword(OUT_CNT_ADDR)); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    total++; if (match_count !== 5'd16) begin bad++; $display("FAIL ovf_mc: got %0d expected 16", match_count); end
    total++; if (mem_diff() != 0) begin bad++; $display("FAIL ovf_memory: got %0d differing bytes expected 0", mem_diff()); end
  endtask

  task automatic test_clamp();
    int cyc; bit gb;
    ext_write(CNT_ADDR, 16'd200);
    for (int i = 0; i < 64; i++) ext_write(CID_BASE + 16'(2 * i), 16'd1);
    ext_write(CID_BASE + 16'(2 * 64), 16'd7);
    fill_out_garbage(16'hAAAA);
    model(16'd1);
    run_scan(16'd1, 0, 0, cyc, gb);
    total++; if (cyc != 131) begin bad++; $display("FAIL clamp_cycles: got %0d expected 131", cyc); end
    @(negedge clock);
    total++; if (mword(OUT_CNT_ADDR) !== 16'd0) begin bad++; $display("FAIL clamp_count: got %0d expected 0", mword(OUT_CNT_ADDR)); end
    total++; if (match_count !== 5'd0) begin bad++; $display("FAIL clamp_mc: got %0d expected 0", match_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clamp_ovf: got %b expected 0", overflow); end
    total++; if (mem_diff() != 0) begin bad++; $display("FAIL clamp_memory: got %0d differing bytes expected 0", mem_diff()); end
  endtask

  task automatic test_arbitration();
    int cyc, cyc2; bit gb;
    ext_write(16'h0700, 16'hBEEF);
    ext_address = 16'h0700;
    #1;
    total++; if (ext_rdata !== 16'hBEEF) begin bad++; $display("FAIL arb_readback: got %h expected beef", ext_rdata); end
    @(negedge clock);
    preload_s1();
    model(16'd1);
    // start held high for the whole scan, ext writes attempted while busy
    run_scan(16'd1, 1, 1, cyc, gb);
    total++; if (gb) begin bad++; $display("FAIL arb_grant: got 1 while busy expected 0"); end
    total++; if (cyc != 15) begin bad++; $display("FAIL arb_no_restart: got %0d cycles expected 15", cyc); end
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arb_start_in_done: got busy %b expected 0", busy); end
    total++; if (mem_diff() != 0) begin bad++; $display("FAIL arb_memory: got %0d differing bytes expected 0", mem_diff()); end
    @(negedge clock);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL arb_start_first_idle: got busy %b expected 1", busy); end
    model(16'd1);
    cyc2 = 1;
    while (done !== 1'b1 && cyc2 < TIMEOUT) begin @(negedge clock); cyc2++; end
    total++; if (cyc2 != 15) begin bad++; $display("FAIL arb_second_scan: got %0d cycles expected 15", cyc2); end
    @(negedge clock);
    total++; if (mword(16'h0700) !== 16'hBEEF) begin bad++; $display("FAIL arb_protected: got %h expected beef", mword(16'h0700)); end
    total++; if (match_count !== 5'd2) begin bad++; $display("FAIL arb_mc: got %0d expected 2", match_count); end
  endtask

  task automatic test_reset_midscan();
    int k, cyc; bit gb;
    preload_s1();
    my_cluster_id = 16'd1; start = 1'b1;
    @(negedge clock);
    k = 1; start = 1'b0;
    while (k < 7) begin @(negedge clock); k++; end
    total++; if (mem_address !== NID_BASE + 16'd4) begin bad++; $display("FAIL rst_at_rd_nid: got addr %h expected 004c", mem_address); end
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b expected 0", done); end
    total++; if (match_count !== 5'd0) begin bad++; $display("FAIL rst_mc: got %0d expected 0", match_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
    total++; if (mem_diff() != 0) begin bad++; $display("FAIL rst_no_writes: got %0d differing bytes expected 0", mem_diff()); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    model(16'd1);
    run_scan(16'd1, 0, 0, cyc, gb);
    total++; if (cyc != 15) begin bad++; $display("FAIL rst_rescan_cycles: got %0d expected 15", cyc); end
    @(negedge clock);
    total++; if (match_count !== 5'd2) begin bad++; $display("FAIL rst_rescan_mc: got %0d expected 2", match_count); end
    total++; if (mem_diff() != 0) begin bad++; $display("FAIL rst_rescan_memory: got %0d differing bytes expected 0", mem_diff()); end
  endtask

  task automatic test_random();
    int cyc, cnt, nfill; bit gb;
    logic [15:0] my;
    for (int it = 0; it < 8; it++) begin
      cnt   = (it == 5) ? int'($urandom_range(65, 90)) : int'($urandom_range(0, 24));
      nfill = (cnt > 64) ? 64 : cnt;
      my    = 16'($urandom_range(0, 2));
      ext_write(CNT_ADDR, 16'(cnt));
      for (int i = 0; i < nfill; i++) begin
        ext_write(NID_BASE + 16'(2 * i), 16'($urandom));
        ext_write(CID_BASE + 16'(2 * i), 16'($urandom_range(0, 2)));
      end
      fill_out_garbage(16'($urandom));
      model(my);
      run_scan(my, 0, 0, cyc, gb);
      total++; if (cyc != exp_cyc) begin bad++; $display("FAIL rnd%0d_cycles: got %0d expected %0d", it, cyc, exp_cyc); end
      @(negedge clock);
      total++; if (int'(match_count) != exp_mc) begin bad++; $display("FAIL rnd%0d_mc: got %0d expected %0d", it, match_count, exp_mc); end
      total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL rnd%0d_ovf: got %b expected %b", it, overflow, exp_ovf); end
      total++; if (mem_diff() != 0) begin bad++; $display("FAIL rnd%0d_memory: got %0d differing bytes expected 0", it, mem_diff()); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; my_cluster_id = 16'h0000;
    ext_address = 16'h0000; ext_wr_en = 1'b0; ext_wdata = 16'h0000;
    mem_clr = 1'b1;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    @(negedge clock);
    @(negedge clock);
    mem_clr = 1'b0;
    test_reset();
    reset = 1'b0;
    @(negedge clock);
    test_preload();
    test_zero_count();
    test_overflow();
    test_clamp();
    test_arbitration();
    test_reset_midscan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
